// File: rtl/rs_alu_scheduler.sv
// rtl/rs_alu_scheduler.sv - ALU reservation station with CDB wake-up and single-issue select
//
// Holds dispatched ALU/branch/jump ops until both operands are available,
// snoops the ALU and LSB result buses for operand wake-up, and issues at most
// one ready op per cycle into registered alu_* outputs.
//
// Optional feature macro: RS_AGE_SELECT_EN
//   defined   - oldest-ready-first select using a per-entry saturating age
//   undefined - lowest-index-ready select, no age storage
//
// Ports:
//   clk_in, rst_in     clock, synchronous active-high reset
//   rdy_in             global enable, low freezes all state
//   clear_in           mispredict flush, kills every entry
//   dsp_*              dispatch request and op payload from the decoder
//   full_out           registered, no free entry
//   cdb_a_*            ALU result broadcast (wins on a tag collision)
//   cdb_l_*            LSB result broadcast
//   alu_*              registered issue port to the ALU

module rs_alu_scheduler #(
  parameter int RS_DEPTH   = 8,
  parameter int IDX_WIDTH  = 3,
  parameter int OP_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  dsp_valid_in,
  input  logic [OP_WIDTH-1:0]   dsp_opcode_in,
  input  logic [ADDR_WIDTH-1:0] dsp_pc_in,
  input  logic [DATA_WIDTH-1:0] dsp_imm_in,
  input  logic [ROB_WIDTH-1:0]  dsp_rob_id_in,
  input  logic [DATA_WIDTH-1:0] dsp_vj_in,
  input  logic [DATA_WIDTH-1:0] dsp_vk_in,
  input  logic [ROB_WIDTH-1:0]  dsp_qj_in,
  input  logic [ROB_WIDTH-1:0]  dsp_qk_in,
  input  logic                  dsp_qj_busy_in,
  input  logic                  dsp_qk_busy_in,
  output logic                  full_out,
  input  logic                  cdb_a_rdy_in,
  input  logic                  cdb_l_rdy_in,
  input  logic [DATA_WIDTH-1:0] cdb_a_result_in,
  input  logic [DATA_WIDTH-1:0] cdb_l_result_in,
  input  logic [ROB_WIDTH-1:0]  cdb_a_rob_id_in,
  input  logic [ROB_WIDTH-1:0]  cdb_l_rob_id_in,
  output logic                  alu_rdy_out,
  output logic [OP_WIDTH-1:0]   alu_opcode_out,
  output logic [ADDR_WIDTH-1:0] alu_pc_out,
  output logic [DATA_WIDTH-1:0] alu_vj_out,
  output logic [DATA_WIDTH-1:0] alu_vk_out,
  output logic [DATA_WIDTH-1:0] alu_imm_out,
  output logic [ROB_WIDTH-1:0]  alu_rob_id_out
);

  // Entry storage
  logic [RS_DEPTH-1:0]   busy;
  logic [RS_DEPTH-1:0]   qj_busy;
  logic [RS_DEPTH-1:0]   qk_busy;
  logic [OP_WIDTH-1:0]   e_opcode [RS_DEPTH];
  logic [ADDR_WIDTH-1:0] e_pc     [RS_DEPTH];
  logic [DATA_WIDTH-1:0] e_imm    [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  e_rob_id [RS_DEPTH];
  logic [DATA_WIDTH-1:0] e_vj     [RS_DEPTH];
  logic [DATA_WIDTH-1:0] e_vk     [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  e_qj     [RS_DEPTH];
  logic [ROB_WIDTH-1:0]  e_qk     [RS_DEPTH];
`ifdef RS_AGE_SELECT_EN
  logic [IDX_WIDTH:0]    e_age    [RS_DEPTH];
  logic [IDX_WIDTH:0]    best_age;
`endif

  logic [RS_DEPTH-1:0]   ready;
  logic                  issue_hit;
  logic [IDX_WIDTH-1:0]  issue_idx;
  logic                  alloc_hit;
  logic [IDX_WIDTH-1:0]  alloc_idx;
  logic                  do_alloc;
  logic [DATA_WIDTH-1:0] byp_vj;
  logic [DATA_WIDTH-1:0] byp_vk;
  logic                  byp_qj_busy;
  logic                  byp_qk_busy;
  logic [RS_DEPTH-1:0]   busy_nxt;
  logic [IDX_WIDTH:0]    busy_cnt;

  // Select looks only at registered state, so an entry woken by this
  // cycle's CDB becomes eligible one cycle later.
  always_comb begin
    ready     = busy & ~qj_busy & ~qk_busy;
    issue_hit = 1'b0;
    issue_idx = '0;
`ifdef RS_AGE_SELECT_EN
    best_age  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      // strict '>' keeps the lowest index on an age tie
      if (ready[i] && (!issue_hit || e_age[i] > best_age)) begin
        issue_hit = 1'b1;
        issue_idx = IDX_WIDTH'(i);
        best_age  = e_age[i];
      end
    end
`else
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ready[i] && !issue_hit) begin
        issue_hit = 1'b1;
        issue_idx = IDX_WIDTH'(i);
      end
    end
`endif
  end

  // Lowest free slot; a slot being freed by this edge's issue is not
  // visible here until the next cycle.
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy[i] && !alloc_hit) begin
        alloc_hit = 1'b1;
        alloc_idx = IDX_WIDTH'(i);
      end
    end
    do_alloc = dsp_valid_in && !full_out && alloc_hit;
  end

  // Same-cycle CDB bypass for the dispatching op
  always_comb begin
    byp_vj      = dsp_vj_in;
    byp_qj_busy = dsp_qj_busy_in;
    if (dsp_qj_busy_in) begin
      if (cdb_a_rdy_in && cdb_a_rob_id_in == dsp_qj_in) begin
        byp_vj      = cdb_a_result_in;
        byp_qj_busy = 1'b0;
      end else if (cdb_l_rdy_in && cdb_l_rob_id_in == dsp_qj_in) begin
        byp_vj      = cdb_l_result_in;
        byp_qj_busy = 1'b0;
      end
    end
    byp_vk      = dsp_vk_in;
    byp_qk_busy = dsp_qk_busy_in;
    if (dsp_qk_busy_in) begin
      if (cdb_a_rdy_in && cdb_a_rob_id_in == dsp_qk_in) begin
        byp_vk      = cdb_a_result_in;
        byp_qk_busy = 1'b0;
      end else if (cdb_l_rdy_in && cdb_l_rob_id_in == dsp_qk_in) begin
        byp_vk      = cdb_l_result_in;
        byp_qk_busy = 1'b0;
      end
    end
  end

  // Occupancy after this edge, used for the registered full flag
  always_comb begin
    busy_nxt = busy;
    if (issue_hit) busy_nxt[issue_idx] = 1'b0;
    if (do_alloc)  busy_nxt[alloc_idx] = 1'b1;
    busy_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      busy_cnt = busy_cnt + (IDX_WIDTH+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy           <= '0;
      qj_busy        <= '0;
      qk_busy        <= '0;
      full_out       <= 1'b0;
      alu_rdy_out    <= 1'b0;
      alu_opcode_out <= '0;
      alu_pc_out     <= '0;
      alu_vj_out     <= '0;
      alu_vk_out     <= '0;
      alu_imm_out    <= '0;
      alu_rob_id_out <= '0;
`ifdef RS_AGE_SELECT_EN
      for (int i = 0; i < RS_DEPTH; i++) e_age[i] <= '0;
`endif
    end else if (rdy_in) begin
      if (clear_in) begin
        busy        <= '0;
        qj_busy     <= '0;
        qk_busy     <= '0;
        full_out    <= 1'b0;
        alu_rdy_out <= 1'b0;
      end else begin
        // Wake-up of resident entries
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (busy[i] && qj_busy[i]) begin
            if (cdb_a_rdy_in && cdb_a_rob_id_in == e_qj[i]) begin
              e_vj[i]    <= cdb_a_result_in;
              qj_busy[i] <= 1'b0;
            end else if (cdb_l_rdy_in && cdb_l_rob_id_in == e_qj[i]) begin
              e_vj[i]    <= cdb_l_result_in;
              qj_busy[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_busy[i]) begin
            if (cdb_a_rdy_in && cdb_a_rob_id_in == e_qk[i]) begin
              e_vk[i]    <= cdb_a_result_in;
              qk_busy[i] <= 1'b0;
            end else if (cdb_l_rdy_in && cdb_l_rob_id_in == e_qk[i]) begin
              e_vk[i]    <= cdb_l_result_in;
              qk_busy[i] <= 1'b0;
            end
          end
        end

        // Issue
        alu_rdy_out <= issue_hit;
        if (issue_hit) begin
          alu_opcode_out <= e_opcode[issue_idx];
          alu_pc_out     <= e_pc[issue_idx];
          alu_vj_out     <= e_vj[issue_idx];
          alu_vk_out     <= e_vk[issue_idx];
          alu_imm_out    <= e_imm[issue_idx];
          alu_rob_id_out <= e_rob_id[issue_idx];
        end

        // Dispatch (target slot is free, so no wake-up write collides)
        if (do_alloc) begin
          e_opcode[alloc_idx] <= dsp_opcode_in;
          e_pc[alloc_idx]     <= dsp_pc_in;
          e_imm[alloc_idx]    <= dsp_imm_in;
          e_rob_id[alloc_idx] <= dsp_rob_id_in;
          e_vj[alloc_idx]     <= byp_vj;
          e_vk[alloc_idx]     <= byp_vk;
          e_qj[alloc_idx]     <= dsp_qj_in;
          e_qk[alloc_idx]     <= dsp_qk_in;
          qj_busy[alloc_idx]  <= byp_qj_busy;
          qk_busy[alloc_idx]  <= byp_qk_busy;
        end

`ifdef RS_AGE_SELECT_EN
        // Ages advance only when a younger op arrives
        if (do_alloc) begin
          for (int i = 0; i < RS_DEPTH; i++) begin
            if (busy[i] && e_age[i] != '1) e_age[i] <= e_age[i] + 1'b1;
          end
          e_age[alloc_idx] <= '0;
        end
`endif

        busy     <= busy_nxt;
        full_out <= (busy_cnt == (IDX_WIDTH+1)'(RS_DEPTH));
      end
    end
  end

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// tb/tb_rs_alu_scheduler.sv - scoreboard bench for rs_alu_scheduler
module tb_rs_alu_scheduler;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        dsp_valid_in;
  logic [5:0]  dsp_opcode_in;
  logic [31:0] dsp_pc_in, dsp_imm_in, dsp_vj_in, dsp_vk_in;
  logic [3:0]  dsp_rob_id_in, dsp_qj_in, dsp_qk_in;
  logic        dsp_qj_busy_in, dsp_qk_busy_in;
  logic        full_out;
  logic        cdb_a_rdy_in, cdb_l_rdy_in;
  logic [31:0] cdb_a_result_in, cdb_l_result_in;
  logic [3:0]  cdb_a_rob_id_in, cdb_l_rob_id_in;
  logic        alu_rdy_out;
  logic [5:0]  alu_opcode_out;
  logic [31:0] alu_pc_out, alu_vj_out, alu_vk_out, alu_imm_out;
  logic [3:0]  alu_rob_id_out;

  always #5 clk = ~clk;

  rs_alu_scheduler dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .dsp_valid_in(dsp_valid_in), .dsp_opcode_in(dsp_opcode_in), .dsp_pc_in(dsp_pc_in),
    .dsp_imm_in(dsp_imm_in), .dsp_rob_id_in(dsp_rob_id_in), .dsp_vj_in(dsp_vj_in),
    .dsp_vk_in(dsp_vk_in), .dsp_qj_in(dsp_qj_in), .dsp_qk_in(dsp_qk_in),
    .dsp_qj_busy_in(dsp_qj_busy_in), .dsp_qk_busy_in(dsp_qk_busy_in), .full_out(full_out),
    .cdb_a_rdy_in(cdb_a_rdy_in), .cdb_l_rdy_in(cdb_l_rdy_in),
    .cdb_a_result_in(cdb_a_result_in), .cdb_l_result_in(cdb_l_result_in),
    .cdb_a_rob_id_in(cdb_a_rob_id_in), .cdb_l_rob_id_in(cdb_l_rob_id_in),
    .alu_rdy_out(alu_rdy_out), .alu_opcode_out(alu_opcode_out), .alu_pc_out(alu_pc_out),
    .alu_vj_out(alu_vj_out), .alu_vk_out(alu_vk_out), .alu_imm_out(alu_imm_out),
    .alu_rob_id_out(alu_rob_id_out)
  );

  // Staged stimulus for the next cycle
  logic        s_rst, s_rdy, s_clear, s_dv, s_pj, s_pk, s_cav, s_clv;
  logic [5:0]  s_op;
  logic [31:0] s_pc, s_imm, s_vj, s_vk, s_ca, s_cl;
  logic [3:0]  s_rob, s_qj, s_qk, s_cat, s_clt;

  // Reference model: a bag of slots plus the visible output state
  typedef struct {
    bit          valid;
    logic [5:0]  op;
    logic [31:0] pc, imm, vj, vk;
    logic [3:0]  rob, qj, qk;
    bit          pj, pk;
    int          serial;
  } slot_t;

  typedef struct packed {
    logic        rdy;
    logic        full;
    logic [5:0]  op;
    logic [31:0] pc, vj, vk, imm;
    logic [3:0]  rob;
  } out_t;

  slot_t m [8];
  out_t  cur;
  out_t  mon_e;
  out_t  exp_q [$];
  int    alloc_count = 0;
  bit    started = 0;
  int    vectors = 0;
  int    miscompares = 0;

  function automatic void check(string name, logic [139:0] act, logic [139:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

`ifdef RS_AGE_SELECT_EN
  function automatic int age_of(int i);
    int a;
    a = alloc_count - m[i].serial - 1;
    return (a > 15) ? 15 : a;
  endfunction
`endif

  // CDB snoop: ALU bus takes precedence on a shared tag
  function automatic void snoop(input logic [3:0] tag, input bit pend_i, input logic [31:0] v_i,
                                output bit pend_o, output logic [31:0] v_o);
    pend_o = pend_i;
    v_o    = v_i;
    if (pend_i) begin
      if (s_cav && s_cat == tag) begin
        v_o = s_ca; pend_o = 0;
      end else if (s_clv && s_clt == tag) begin
        v_o = s_cl; pend_o = 0;
      end
    end
  endfunction

  function automatic void model_step();
    int pick, fs, n;
    bit p;
    logic [31:0] v;
    if (s_rst) begin
      foreach (m[i]) m[i].valid = 0;
      cur = '0;
      return;
    end
    if (!s_rdy) return;
    if (s_clear) begin
      foreach (m[i]) m[i].valid = 0;
      cur.rdy  = 0;
      cur.full = 0;
      return;
    end
    pick = -1;
    for (int i = 0; i < 8; i++) begin
      if (m[i].valid && !m[i].pj && !m[i].pk) begin
`ifdef RS_AGE_SELECT_EN
        if (pick < 0 || age_of(i) > age_of(pick)) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (m[i].valid) begin
        snoop(m[i].qj, m[i].pj, m[i].vj, p, v); m[i].pj = p; m[i].vj = v;
        snoop(m[i].qk, m[i].pk, m[i].vk, p, v); m[i].pk = p; m[i].vk = v;
      end
    end
    if (s_dv && !cur.full) begin
      fs = -1;
      for (int i = 0; i < 8; i++) if (!m[i].valid && fs < 0) fs = i;
      if (fs >= 0) begin
        m[fs].valid = 1; m[fs].op = s_op; m[fs].pc = s_pc; m[fs].imm = s_imm;
        m[fs].rob = s_rob; m[fs].qj = s_qj; m[fs].qk = s_qk;
        snoop(s_qj, s_pj, s_vj, p, v); m[fs].pj = p; m[fs].vj = v;
        snoop(s_qk, s_pk, s_vk, p, v); m[fs].pk = p; m[fs].vk = v;
        m[fs].serial = alloc_count;
        alloc_count++;
      end
    end
    if (pick >= 0) begin
      cur.rdy = 1; cur.op = m[pick].op; cur.pc = m[pick].pc; cur.vj = m[pick].vj;
      cur.vk = m[pick].vk; cur.imm = m[pick].imm; cur.rob = m[pick].rob;
      m[pick].valid = 0;
    end else begin
      cur.rdy = 0;
    end
    n = 0;
    foreach (m[i]) if (m[i].valid) n++;
    cur.full = (n == 8);
  endfunction

  task automatic idle();
    s_rst = 0; s_rdy = 1; s_clear = 0; s_dv = 0; s_pj = 0; s_pk = 0;
    s_cav = 0; s_clv = 0; s_op = '0; s_pc = '0; s_imm = '0; s_vj = '0; s_vk = '0;
    s_ca = '0; s_cl = '0; s_rob = '0; s_qj = '0; s_qk = '0; s_cat = '0; s_clt = '0;
  endtask

  task automatic dsp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input logic [31:0] imm, input logic [3:0] rob,
                     input bit pj, input logic [3:0] qj, input bit pk, input logic [3:0] qk);
    s_dv = 1; s_op = op; s_pc = 32'h1000 + {26'd0, op}; s_vj = vj; s_vk = vk; s_imm = imm;
    s_rob = rob; s_pj = pj; s_qj = qj; s_pk = pk; s_qk = qk;
  endtask

  // Drive staged inputs just after a falling edge, predict the next rising edge
  task automatic tick();
    @(negedge clk);
    #1;
    rst_in = s_rst; rdy_in = s_rdy; clear_in = s_clear; dsp_valid_in = s_dv;
    dsp_opcode_in = s_op; dsp_pc_in = s_pc; dsp_imm_in = s_imm; dsp_rob_id_in = s_rob;
    dsp_vj_in = s_vj; dsp_vk_in = s_vk; dsp_qj_in = s_qj; dsp_qk_in = s_qk;
    dsp_qj_busy_in = s_pj; dsp_qk_busy_in = s_pk;
    cdb_a_rdy_in = s_cav; cdb_a_result_in = s_ca; cdb_a_rob_id_in = s_cat;
    cdb_l_rdy_in = s_clv; cdb_l_result_in = s_cl; cdb_l_rob_id_in = s_clt;
    model_step();
    exp_q.push_back(cur);
    started = 1;
  endtask

  task automatic idle_ticks(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: one expected output state per rising edge
  always @(negedge clk) begin
    if (started && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("alu_rdy_out", {139'd0, alu_rdy_out}, {139'd0, mon_e.rdy});
      check("full_out", {139'd0, full_out}, {139'd0, mon_e.full});
      check("alu_payload",
            {2'd0, alu_opcode_out, alu_pc_out, alu_vj_out, alu_vk_out, alu_imm_out, alu_rob_id_out},
            {2'd0, mon_e.op, mon_e.pc, mon_e.vj, mon_e.vk, mon_e.imm, mon_e.rob});
    end
  end

  initial begin
    idle();
    s_rst = 1;
    tick(); tick();

    // ready-at-dispatch issues after the following edge, one-cycle pulse
    idle(); dsp(6'h13, 32'd5, 32'd0, 32'd7, 4'd3, 0, 4'd0, 0, 4'd0); tick();
    idle_ticks(3);

    // wake-up two cycles after dispatch, then same-cycle bypass
    idle(); dsp(6'h33, 32'd0, 32'd4, 32'd0, 4'd4, 1, 4'd2, 0, 4'd0); tick();
    idle_ticks(1);
    idle(); s_cav = 1; s_cat = 4'd2; s_ca = 32'd10; tick();
    idle_ticks(2);
    idle(); dsp(6'h33, 32'd0, 32'd4, 32'd0, 4'd5, 1, 4'd2, 0, 4'd0);
    s_cav = 1; s_cat = 4'd2; s_ca = 32'd10; tick();
    idle_ticks(2);

    // fill all slots with pending ops, overflow dispatch is dropped
    for (int i = 0; i < 8; i++) begin
      idle(); dsp(6'(i + 8), 32'd0, 32'd0, 32'(i), 4'(i), 1, 4'(i + 8), 0, 4'd0); tick();
    end
    idle(); dsp(6'h3f, 32'd1, 32'd1, 32'd1, 4'd15, 0, 4'd0, 0, 4'd0); tick();
    // free slot 1, refill it so that slot 5 is the older of the two
    idle(); s_cav = 1; s_cat = 4'd9; s_ca = 32'h99; tick();
    idle_ticks(2);
    idle(); dsp(6'h21, 32'd0, 32'd0, 32'd0, 4'd14, 1, 4'd6, 0, 4'd0); tick();
    idle(); s_cav = 1; s_cat = 4'd13; s_ca = 32'h13; s_clv = 1; s_clt = 4'd6; s_cl = 32'h66; tick();
    idle_ticks(3);

    // both buses wake both operands; duplicate tag picks the ALU bus
    idle(); dsp(6'h01, 32'd0, 32'd0, 32'd0, 4'd1, 1, 4'd1, 1, 4'd5); tick();
    idle(); s_cav = 1; s_cat = 4'd1; s_ca = 32'h11; s_clv = 1; s_clt = 4'd5; s_cl = 32'h55; tick();
    idle_ticks(1);
    idle(); dsp(6'h02, 32'd0, 32'd0, 32'd0, 4'd2, 1, 4'd7, 1, 4'd7); tick();
    idle(); s_cav = 1; s_cat = 4'd7; s_ca = 32'haaaa; s_clv = 1; s_clt = 4'd7; s_cl = 32'hbbbb; tick();
    idle_ticks(2);

    // flush while an issue is pending
    idle(); s_cav = 1; s_cat = 4'd8; s_ca = 32'h88; tick();
    idle(); s_clear = 1; dsp(6'h05, 32'd1, 32'd2, 32'd3, 4'd9, 0, 4'd0, 0, 4'd0); tick();
    idle_ticks(3);

    // freeze with an issue pulse on the outputs
    idle(); dsp(6'h06, 32'd6, 32'd6, 32'd6, 4'd6, 0, 4'd0, 0, 4'd0); tick();
    idle(); dsp(6'h07, 32'd7, 32'd7, 32'd7, 4'd7, 0, 4'd0, 0, 4'd0); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); s_rdy = 0; s_clear = (i == 1); s_cav = 1; s_cat = 4'd0;
      dsp(6'h08, 32'd8, 32'd8, 32'd8, 4'd8, 0, 4'd0, 0, 4'd0); tick();
    end
    idle_ticks(3);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      s_rdy   = ($urandom_range(0, 9) != 0);
      s_clear = ($urandom_range(0, 149) == 0);
      if (!cur.full && $urandom_range(0, 1) == 1) begin
        dsp(6'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
            ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
        s_pc = $urandom;
      end
      s_cav = $urandom_range(0, 1); s_cat = 4'($urandom_range(0, 15)); s_ca = $urandom;
      s_clv = $urandom_range(0, 1); s_clt = 4'($urandom_range(0, 15)); s_cl = $urandom;
      tick();
    end
    idle_ticks(4);

    @(negedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 140'(exp_q.size()), 140'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
